turn_scheduler: RTL and testbench

Sequences one battle turn: orders the two attacks by speed, time-shares the single damage `calculation` unit between player and enemy, and resolves accuracy. It drains the target's HP one point per video frame, holds each attack's text until the player acknowledges it, and reports faints. It sits between the battle FSM (which issues `start_turn` after move selection) and the HP registers / text overlays.

---
 rtl/battle_pkg.sv | 34 +++
 rtl/hp_drain.sv | 50 +++++
 rtl/turn_scheduler.sv | 201 ++++++++++++++++++++
 tb/tb_turn_scheduler.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/battle_pkg.sv
// Shared battle definitions: turn sequencer states, text overlay selects and
// the keycodes the battle FSM decodes.
package battle_pkg;

    localparam int unsigned SHOW_W = 2;
    localparam int unsigned KEY_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ORDER = 3'd1,
        ST_CALC  = 3'd2,
        ST_HIT   = 3'd3,
        ST_DRAIN = 3'd4,
        ST_TEXT  = 3'd5,
        ST_DONE  = 3'd6
    } turn_state_e;

    localparam logic [SHOW_W-1:0] SHOW_NONE   = SHOW_W'(0);
    localparam logic [SHOW_W-1:0] SHOW_PLAYER = SHOW_W'(1);
    localparam logic [SHOW_W-1:0] SHOW_ENEMY  = SHOW_W'(2);

    // PS/2 set-2 make codes used by move selection and text acknowledge
    localparam logic [KEY_W-1:0] KEY_ENTER = KEY_W'(8'h5A);
    localparam logic [KEY_W-1:0] KEY_ESC   = KEY_W'(8'h76);
    localparam logic [KEY_W-1:0] KEY_UP    = KEY_W'(8'h75);
    localparam logic [KEY_W-1:0] KEY_DOWN  = KEY_W'(8'h72);
    localparam logic [KEY_W-1:0] KEY_LEFT  = KEY_W'(8'h6B);
    localparam logic [KEY_W-1:0] KEY_RIGHT = KEY_W'(8'h74);

    function automatic logic [SHOW_W-1:0] show_sel(input logic is_player);
        return is_player ? SHOW_PLAYER : SHOW_ENEMY;
    endfunction

endpackage

// File: rtl/hp_drain.sv
// Tick-gated damage down-counter: requests one HP decrement per frame tick and
// signals completion when damage is spent or the target has no HP left.
module hp_drain
    import battle_pkg::*;
#(
    parameter int unsigned HP_W = 8
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            load,
    input  logic [HP_W-1:0] load_val,
    input  logic            clear,
    input  logic            active,
    input  logic            tick,
    input  logic            target_zero,
    output logic            dec_c,
    output logic            done_c
);

    logic [HP_W-1:0] remaining_q;
    logic [HP_W-1:0] remaining_d;

    always_comb begin
        remaining_d = remaining_q;
        dec_c       = 1'b0;
        done_c      = 1'b0;
        if (clear) begin
            remaining_d = '0;
        end else if (load) begin
            remaining_d = load_val;
        end else if (active && tick) begin
            // Overkill damage is dropped once the target reaches zero
            if ((remaining_q == HP_W'(0)) || target_zero) begin
                done_c = 1'b1;
            end else begin
                dec_c       = 1'b1;
                remaining_d = remaining_q - HP_W'(1);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            remaining_q <= '0;
        end else begin
            remaining_q <= remaining_d;
        end
    end

endmodule

// File: rtl/turn_scheduler.sv
// Battle turn sequencer: orders both attacks by speed, shares the damage unit,
// resolves accuracy, drains HP per frame and waits for text acknowledgement.
module turn_scheduler
    import battle_pkg::*;
#(
    parameter int unsigned HP_W    = 8,
    parameter int unsigned ACC_MOD = 100
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start_turn,
    input  logic [HP_W-1:0]   player_speed,
    input  logic [HP_W-1:0]   enemy_speed,
    input  logic [HP_W-1:0]   player_acc,
    input  logic [HP_W-1:0]   enemy_acc,
    input  logic [7:0]        rand_num,
    input  logic [HP_W-1:0]   calc_damage,
    input  logic [HP_W-1:0]   player_hp,
    input  logic [HP_W-1:0]   enemy_hp,
    input  logic              frame_tick,
    input  logic              text_ack,
    output logic              calc_is_player,
    output logic              dec_player,
    output logic              dec_enemy,
    output logic [SHOW_W-1:0] show_text,
    output logic              hit,
    output logic              player_fainted,
    output logic              enemy_fainted,
    output logic              turn_done,
    output logic              busy
);

    localparam int unsigned ROLL_W = 32;

    turn_state_e       state_q, state_d;
    logic              atk_is_player_q, atk_is_player_d;
    logic              second_q, second_d;
    logic              hit_q, hit_d;
    logic [SHOW_W-1:0] show_text_q, show_text_d;
    logic              player_fainted_q, player_fainted_d;
    logic              enemy_fainted_q, enemy_fainted_d;
    logic              turn_done_q, turn_done_d;
    logic              busy_q, busy_d;
    logic              dec_player_q, dec_player_d;
    logic              dec_enemy_q, dec_enemy_d;

    logic              drain_load_c;
    logic              drain_clear_c;
    logic              drain_active_c;
    logic              drain_dec_c;
    logic              drain_done_c;

    logic [HP_W-1:0]   acc_c;
    logic [ROLL_W-1:0] roll_c;
    logic              acc_ok_c;
    logic              target_zero_c;

    // Accuracy roll in 1..ACC_MOD against the current attacker's move
    assign acc_c         = atk_is_player_q ? player_acc : enemy_acc;
    assign roll_c        = (ROLL_W'(rand_num) % ROLL_W'(ACC_MOD)) + ROLL_W'(1);
    assign acc_ok_c      = (roll_c <= ROLL_W'(acc_c));
    assign target_zero_c = atk_is_player_q ? (enemy_hp == HP_W'(0))
                                           : (player_hp == HP_W'(0));

    hp_drain #(
        .HP_W (HP_W)
    ) u_hp_drain (
        .Clk         (Clk),
        .Reset       (Reset),
        .load        (drain_load_c),
        .load_val    (calc_damage),
        .clear       (drain_clear_c),
        .active      (drain_active_c),
        .tick        (frame_tick),
        .target_zero (target_zero_c),
        .dec_c       (drain_dec_c),
        .done_c      (drain_done_c)
    );

    always_comb begin
        state_d          = state_q;
        atk_is_player_d  = atk_is_player_q;
        second_d         = second_q;
        hit_d            = hit_q;
        show_text_d      = show_text_q;
        player_fainted_d = player_fainted_q;
        enemy_fainted_d  = enemy_fainted_q;
        turn_done_d      = 1'b0;
        dec_player_d     = 1'b0;
        dec_enemy_d      = 1'b0;
        drain_load_c     = 1'b0;
        drain_clear_c    = 1'b0;
        drain_active_c   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_turn) begin
                    state_d = ST_ORDER;
                end
            end
            ST_ORDER: begin
                player_fainted_d = 1'b0;
                enemy_fainted_d  = 1'b0;
                second_d         = 1'b0;
                // Speed tie goes to the enemy
                atk_is_player_d  = (player_speed > enemy_speed);
                state_d          = ST_CALC;
            end
            ST_CALC: begin
                drain_load_c = 1'b1;
                state_d      = ST_HIT;
            end
            ST_HIT: begin
                hit_d = acc_ok_c;
                if (acc_ok_c) begin
                    state_d = ST_DRAIN;
                end else begin
                    drain_clear_c = 1'b1;
                    show_text_d   = show_sel(atk_is_player_q);
                    state_d       = ST_TEXT;
                end
            end
            ST_DRAIN: begin
                drain_active_c = 1'b1;
                dec_enemy_d    = drain_dec_c & atk_is_player_q;
                dec_player_d   = drain_dec_c & ~atk_is_player_q;
                if (drain_done_c) begin
                    show_text_d = show_sel(atk_is_player_q);
                    state_d     = ST_TEXT;
                end
            end
            ST_TEXT: begin
                if (text_ack) begin
                    show_text_d = SHOW_NONE;
                    hit_d       = 1'b0;
                    if (target_zero_c) begin
                        player_fainted_d = player_fainted_q | ~atk_is_player_q;
                        enemy_fainted_d  = enemy_fainted_q | atk_is_player_q;
                        turn_done_d      = 1'b1;
                        state_d          = ST_DONE;
                    end else if (!second_q) begin
                        second_d        = 1'b1;
                        atk_is_player_d = ~atk_is_player_q;
                        state_d         = ST_CALC;
                    end else begin
                        turn_done_d = 1'b1;
                        state_d     = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q          <= ST_IDLE;
            atk_is_player_q  <= 1'b0;
            second_q         <= 1'b0;
            hit_q            <= 1'b0;
            show_text_q      <= SHOW_NONE;
            player_fainted_q <= 1'b0;
            enemy_fainted_q  <= 1'b0;
            turn_done_q      <= 1'b0;
            busy_q           <= 1'b0;
            dec_player_q     <= 1'b0;
            dec_enemy_q      <= 1'b0;
        end else begin
            state_q          <= state_d;
            atk_is_player_q  <= atk_is_player_d;
            second_q         <= second_d;
            hit_q            <= hit_d;
            show_text_q      <= show_text_d;
            player_fainted_q <= player_fainted_d;
            enemy_fainted_q  <= enemy_fainted_d;
            turn_done_q      <= turn_done_d;
            busy_q           <= busy_d;
            dec_player_q     <= dec_player_d;
            dec_enemy_q      <= dec_enemy_d;
        end
    end

    // The attacker flag is stable for a whole attack, so it drives the calc unit
    assign calc_is_player = atk_is_player_q;
    assign dec_player     = dec_player_q;
    assign dec_enemy      = dec_enemy_q;
    assign show_text      = show_text_q;
    assign hit            = hit_q;
    assign player_fainted = player_fainted_q;
    assign enemy_fainted  = enemy_fainted_q;
    assign turn_done      = turn_done_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_turn_scheduler.sv
// Self-checking bench for turn_scheduler: models the HP registers, calc unit,
// frame ticks and ENTER presses, and compares each turn to a rule-level model.
module tb_turn_scheduler;

    logic       Clk;
    logic       Reset;
    logic       start_turn;
    logic [7:0] player_speed, enemy_speed;
    logic [7:0] player_acc, enemy_acc;
    logic [7:0] rand_num;
    logic [7:0] calc_damage;
    logic [7:0] player_hp, enemy_hp;
    logic       frame_tick;
    logic       text_ack;
    logic       calc_is_player;
    logic       dec_player, dec_enemy;
    logic [1:0] show_text;
    logic       hit;
    logic       player_fainted, enemy_fainted;
    logic       turn_done;
    logic       busy;

    logic [7:0] dmg_player, dmg_enemy;

    int n_checks = 0;
    int n_fail   = 0;

    turn_scheduler #(
        .HP_W    (8),
        .ACC_MOD (100)
    ) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .start_turn     (start_turn),
        .player_speed   (player_speed),
        .enemy_speed    (enemy_speed),
        .player_acc     (player_acc),
        .enemy_acc      (enemy_acc),
        .rand_num       (rand_num),
        .calc_damage    (calc_damage),
        .player_hp      (player_hp),
        .enemy_hp       (enemy_hp),
        .frame_tick     (frame_tick),
        .text_ack       (text_ack),
        .calc_is_player (calc_is_player),
        .dec_player     (dec_player),
        .dec_enemy      (dec_enemy),
        .show_text      (show_text),
        .hit            (hit),
        .player_fainted (player_fainted),
        .enemy_fainted  (enemy_fainted),
        .turn_done      (turn_done),
        .busy           (busy)
    );

    // Shared damage calculator: fixed per-side damage for the turn
    assign calc_damage = calc_is_player ? dmg_player : dmg_enemy;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Full turn with model-predicted outcome; noise adds ignored start/ack pulses
    task automatic run_turn(input string name, input int ps, input int es,
                            input int pa, input int ea, input int r1, input int r2,
                            input int pd, input int ed, input int php, input int ehp,
                            input bit noise);
        int ph, eh, tgt, dmg, acc, r, dealt, exp_n, n_shown;
        int atk_idx, ack_wait, gap, done_cnt, got_p, got_e;
        bit pf, atkp, h, exp_pfaint, exp_efaint, pend_p, pend_e;
        logic [1:0] exp_show [2];
        logic       exp_hit  [2];
        int         exp_dealt[2];
        int         de [3];
        int         dp [3];
        bit         shown [3];
        logic [1:0] show_obs [3];
        logic       hit_obs  [3];

        // Reference: apply the battle rules attack by attack
        ph = php; eh = ehp; exp_n = 0; exp_pfaint = 0; exp_efaint = 0;
        pf = (ps > es);
        for (int a = 0; a < 2; a++) begin
            atkp  = (a == 0) ? pf : !pf;
            r     = (a == 0) ? r1 : r2;
            acc   = atkp ? pa : ea;
            dmg   = atkp ? pd : ed;
            h     = ((r % 100) + 1) <= acc;
            tgt   = atkp ? eh : ph;
            dealt = h ? ((dmg < tgt) ? dmg : tgt) : 0;
            tgt   = tgt - dealt;
            if (atkp) eh = tgt; else ph = tgt;
            exp_show[a]  = atkp ? 2'd1 : 2'd2;
            exp_hit[a]   = h;
            exp_dealt[a] = dealt;
            exp_n++;
            if (tgt == 0) begin
                if (atkp) exp_efaint = 1; else exp_pfaint = 1;
                break;
            end
        end

        player_speed = 8'(ps); enemy_speed = 8'(es);
        player_acc = 8'(pa); enemy_acc = 8'(ea);
        dmg_player = 8'(pd); dmg_enemy = 8'(ed);
        player_hp = 8'(php); enemy_hp = 8'(ehp);
        rand_num = 8'(r1);
        de = '{0, 0, 0}; dp = '{0, 0, 0}; shown = '{0, 0, 0};
        show_obs = '{2'd0, 2'd0, 2'd0}; hit_obs = '{1'b0, 1'b0, 1'b0};
        atk_idx = 0; ack_wait = 0; done_cnt = 0; pend_p = 0; pend_e = 0;
        gap = $urandom_range(3, 0);

        start_turn = 1'b1;
        @(posedge Clk); #1;
        start_turn = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL %s busy_after_start: got %b want 1", name, busy);
        end
        @(posedge Clk); #1;
        n_checks++;
        if (calc_is_player !== pf) begin
            n_fail++; $display("FAIL %s first_calc_is_player: got %b want %b", name, calc_is_player, pf);
        end
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        n_checks++;
        if (show_text !== (exp_hit[0] ? 2'd0 : exp_show[0])) begin
            n_fail++; $display("FAIL %s show_at_t4: got %0d want %0d", name, show_text,
                               exp_hit[0] ? 2'd0 : exp_show[0]);
        end

        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (pend_e) enemy_hp = enemy_hp - 8'd1;
            if (pend_p) player_hp = player_hp - 8'd1;
            pend_e = (dec_enemy === 1'b1);
            pend_p = (dec_player === 1'b1);
            if (pend_e) de[atk_idx]++;
            if (pend_p) dp[atk_idx]++;
            if (turn_done === 1'b1) done_cnt++;
            if (done_cnt > 0 && busy === 1'b0) break;
            frame_tick = 1'b0; text_ack = 1'b0; start_turn = 1'b0;
            if (show_text !== 2'd0 && atk_idx < 2) begin
                if (!shown[atk_idx]) begin
                    shown[atk_idx]    = 1'b1;
                    show_obs[atk_idx] = show_text;
                    hit_obs[atk_idx]  = hit;
                    ack_wait          = $urandom_range(4, 0);
                end
                if (ack_wait == 0) begin
                    text_ack = 1'b1;
                    atk_idx++;
                    rand_num = 8'(r2);
                end else begin
                    ack_wait--;
                end
            end else if (noise && busy === 1'b1) begin
                if ($urandom_range(5, 0) == 0) text_ack = 1'b1;
                if ($urandom_range(5, 0) == 0) start_turn = 1'b1;
            end
            if (gap == 0) begin
                frame_tick = 1'b1;
                gap = $urandom_range(3, 1);
            end else begin
                gap--;
            end
            @(posedge Clk); #1;
        end
        frame_tick = 1'b0; text_ack = 1'b0; start_turn = 1'b0;

        n_checks++;
        if (done_cnt != 1) begin
            n_fail++; $display("FAIL %s turn_done_count: got %0d want 1", name, done_cnt);
        end
        n_shown = int'(shown[0]) + int'(shown[1]) + int'(shown[2]);
        n_checks++;
        if (n_shown != exp_n) begin
            n_fail++; $display("FAIL %s attacks_shown: got %0d want %0d", name, n_shown, exp_n);
        end
        for (int a = 0; a < 2; a++) begin
            if (a < exp_n) begin
                got_e = de[a]; got_p = dp[a];
                n_checks++;
                if (show_obs[a] !== exp_show[a]) begin
                    n_fail++; $display("FAIL %s show[%0d]: got %0d want %0d", name, a, show_obs[a], exp_show[a]);
                end
                n_checks++;
                if (hit_obs[a] !== exp_hit[a]) begin
                    n_fail++; $display("FAIL %s hit[%0d]: got %b want %b", name, a, hit_obs[a], exp_hit[a]);
                end
                n_checks++;
                if ((exp_show[a] == 2'd1 ? got_e : got_p) != exp_dealt[a]) begin
                    n_fail++; $display("FAIL %s dec_target[%0d]: got %0d want %0d", name, a,
                                       (exp_show[a] == 2'd1 ? got_e : got_p), exp_dealt[a]);
                end
                n_checks++;
                if ((exp_show[a] == 2'd1 ? got_p : got_e) != 0) begin
                    n_fail++; $display("FAIL %s dec_wrong_side[%0d]: got %0d want 0", name, a,
                                       (exp_show[a] == 2'd1 ? got_p : got_e));
                end
            end
        end
        n_checks++;
        if (player_hp !== 8'(ph) || enemy_hp !== 8'(eh)) begin
            n_fail++; $display("FAIL %s final_hp: got %0d/%0d want %0d/%0d", name, player_hp, enemy_hp, ph, eh);
        end
        n_checks++;
        if (player_fainted !== exp_pfaint || enemy_fainted !== exp_efaint) begin
            n_fail++; $display("FAIL %s faint: got %b/%b want %b/%b", name, player_fainted, enemy_fainted,
                               exp_pfaint, exp_efaint);
        end
        n_checks++;
        if (show_text !== 2'd0) begin
            n_fail++; $display("FAIL %s show_idle: got %0d want 0", name, show_text);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        start_turn = 1'b0; frame_tick = 1'b0; text_ack = 1'b0;
        player_speed = 8'd0; enemy_speed = 8'd0; player_acc = 8'd0; enemy_acc = 8'd0;
        rand_num = 8'd0; dmg_player = 8'd0; dmg_enemy = 8'd0;
        player_hp = 8'd20; enemy_hp = 8'd20;
        repeat (3) @(posedge Clk);
        #1;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: got %b want 0", busy);
        end
        n_checks++;
        if (show_text !== 2'd0) begin
            n_fail++; $display("FAIL reset_show_text: got %0d want 0", show_text);
        end
        n_checks++;
        if ({calc_is_player, dec_player, dec_enemy, hit, player_fainted, enemy_fainted, turn_done} !== 7'd0) begin
            n_fail++; $display("FAIL reset_outputs: got %b want 0000000",
                               {calc_is_player, dec_player, dec_enemy, hit, player_fainted, enemy_fainted, turn_done});
        end
        Reset = 1'b0;
        @(posedge Clk); #1;
    endtask

    task automatic test_player_first();
        run_turn("player_first", 60, 40, 100, 100, 7, 13, 5, 3, 20, 20, 0);
    endtask

    task automatic test_speed_tie();
        run_turn("speed_tie", 50, 50, 100, 100, 0, 99, 4, 6, 20, 20, 0);
    endtask

    task automatic test_miss();
        run_turn("player_miss", 60, 40, 50, 100, 60, 60, 5, 3, 20, 20, 0);
    endtask

    task automatic test_faint();
        run_turn("enemy_faint", 60, 40, 100, 100, 10, 10, 10, 3, 20, 4, 0);
    endtask

    task automatic test_reset_mid_drain();
        int decs;
        player_speed = 8'd60; enemy_speed = 8'd40; player_acc = 8'd100; enemy_acc = 8'd100;
        dmg_player = 8'd5; dmg_enemy = 8'd3; player_hp = 8'd20; enemy_hp = 8'd20; rand_num = 8'd0;
        decs = 0;
        start_turn = 1'b1;
        @(posedge Clk); #1;
        start_turn = 1'b0;
        for (int cyc = 0; cyc < 200 && decs < 2; cyc++) begin
            if (dec_enemy === 1'b1) decs++;
            frame_tick = (decs < 2) && (cyc % 3 == 0);
            @(posedge Clk); #1;
        end
        frame_tick = 1'b0;
        n_checks++;
        if (decs != 2) begin
            n_fail++; $display("FAIL mid_drain_decs: got %0d want 2", decs);
        end
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        n_checks++;
        if ({busy, calc_is_player, dec_player, dec_enemy, show_text, hit, player_fainted, enemy_fainted, turn_done} !== 10'd0) begin
            n_fail++; $display("FAIL mid_drain_reset_outputs: got %b want 0",
                               {busy, calc_is_player, dec_player, dec_enemy, show_text, hit,
                                player_fainted, enemy_fainted, turn_done});
        end
        @(posedge Clk); #1;
        run_turn("after_reset", 60, 40, 100, 100, 3, 3, 5, 3, 20, 20, 0);
    endtask

    task automatic test_ignored_pulses();
        run_turn("ignored_pulses", 90, 10, 100, 100, 1, 2, 12, 9, 30, 30, 1);
    endtask

    task automatic test_random();
        int ps, es, pa, ea;
        for (int i = 0; i < 30; i++) begin
            ps = $urandom_range(255, 0);
            es = ($urandom_range(3, 0) == 0) ? ps : $urandom_range(255, 0);
            pa = ($urandom_range(3, 0) == 0) ? 100 : $urandom_range(100, 0);
            ea = ($urandom_range(3, 0) == 0) ? 100 : $urandom_range(100, 0);
            run_turn($sformatf("random_%0d", i), ps, es, pa, ea,
                     $urandom_range(255, 0), $urandom_range(255, 0),
                     $urandom_range(25, 0), $urandom_range(25, 0),
                     $urandom_range(40, 0), $urandom_range(40, 0),
                     1'($urandom_range(1, 0)));
            repeat ($urandom_range(3, 0)) @(posedge Clk);
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_player_first();
        test_speed_tie();
        test_miss();
        test_faint();
        test_reset_mid_drain();
        test_ignored_pulses();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
